// File: rtl/wb_regfile.sv
// Architectural register file x0..x31 with one writeback port, two bypassed combinational
// read ports and a retired-write counter. Optional RAW scoreboard: WB_REGFILE_SCOREBOARD_EN.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    rs1_number,
   input  logic [AW-1:0]    rs2_number,
   output logic [XLEN-1:0]  a_val,
   output logic [XLEN-1:0]  b_val,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_rd_number,
   input  logic [XLEN-1:0]  wb_value,
   output logic [CNT_W-1:0] wb_count,
   input  logic             issue_valid,
   input  logic [AW-1:0]    issue_rd_number,
   output logic             hazard
);

   localparam int NREG = 1 << AW;

   logic [XLEN-1:0]  regs [1:NREG-1];
   logic [CNT_W-1:0] count_q;
   logic             wr_en;
   logic             byp_a;
   logic             byp_b;

   // wb_valid has no ready: every write presented is accepted at the next rising edge.
   // Writes to x0 are dropped entirely, so they never bypass, count or clear busy state.
   assign wr_en = wb_valid && (wb_rd_number != '0);
   assign byp_a = wr_en && (wb_rd_number == rs1_number);
   assign byp_b = wr_en && (wb_rd_number == rs2_number);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wb_rd_number] <= wb_value;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (wr_en) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign wb_count = count_q;

   // Outputs are forced to zero while reset is held so RR never sees stale data.
   always_comb begin
      a_val = '0;
      b_val = '0;
      if (reset_n) begin
         if (byp_a) begin
            a_val = wb_value;
         end else if (rs1_number != '0) begin
            a_val = regs[rs1_number];
         end
         if (byp_b) begin
            b_val = wb_value;
         end else if (rs2_number != '0) begin
            b_val = regs[rs2_number];
         end
      end
   end

`ifdef WB_REGFILE_SCOREBOARD_EN
   logic [NREG-1:0] busy;
   logic            haz_a;
   logic            haz_b;

   // The set is scheduled after the clear so a same-cycle issue to the same index wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= '0;
      end else begin
         if (wr_en) begin
            busy[wb_rd_number] <= 1'b0;
         end
         if (issue_valid && (issue_rd_number != '0)) begin
            busy[issue_rd_number] <= 1'b1;
         end
      end
   end

   assign haz_a  = (rs1_number != '0) && busy[rs1_number] && !byp_a;
   assign haz_b  = (rs2_number != '0) && busy[rs2_number] && !byp_b;
   assign hazard = reset_n && (haz_a || haz_b);
`else
   logic unused_issue;
   assign unused_issue = issue_valid ^ (^issue_rd_number);
   assign hazard       = 1'b0;
`endif

endmodule
